// File: rtl/irq_ctrl_if.sv
// Register bus between a CPU-side master and the interrupt controller.
// A transfer takes two cycles: wt is high in the first, data_out is valid in the second.
interface irq_ctrl_if;
   logic        en;
   logic        wr;
   logic [3:2]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        wt;

   modport master (
      output en, wr, addr, data_in,
      input  data_out, wt
   );

   modport slave (
      input  en, wr, addr, data_in,
      output data_out, wt
   );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source synchronizer, level/edge pending capture,
// mask, highest-index ID, and a two-cycle register bus.
// Register map (word address): 0 PENDING (W1C), 1 MASK, 2 MODE (1 = edge), 3 ID.
module irq_ctrl #(
   parameter int unsigned NUM_SRC     = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   irq_ctrl_if.slave          bus,
   input  logic [NUM_SRC-1:0] src_irq,
   output logic [NUM_SRC-1:0] irq,
   output logic               irq_any
);

   logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
   logic [NUM_SRC-1:0] r_hist;
   logic [NUM_SRC-1:0] r_pend;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_mode;
   logic [NUM_SRC-1:0] r_irq;
   logic               r_irq_any;
   logic               r_done;
   logic [31:0]        r_dout;

   logic [NUM_SRC-1:0] w_s;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_mode_chg;
   logic [NUM_SRC-1:0] w_mode_nxt;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic               w_wt;
   logic               w_commit;
   logic               w_rd_start;
   logic               w_wr_pend;
   logic               w_wr_mask;
   logic               w_wr_mode;
   logic [4:0]         w_id;
   logic [31:0]        w_rdata;
   logic               w_unused;

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_wdata    = bus.data_in[NUM_SRC-1:0];
   assign w_unused   = &{1'b0, bus.data_in};

   // Access handshake: first cycle waits, second cycle completes.
   assign w_wt       = bus.en & ~r_done;
   assign w_commit   = bus.en & r_done & bus.wr;
   assign w_rd_start = bus.en & ~r_done & ~bus.wr;

   assign w_wr_pend  = w_commit && (bus.addr == 2'd0);
   assign w_wr_mask  = w_commit && (bus.addr == 2'd1);
   assign w_wr_mode  = w_commit && (bus.addr == 2'd2);

   assign w_edge     = w_s & ~r_hist;
   assign w_clr      = w_wr_pend ? w_wdata : '0;
   assign w_mode_chg = w_wr_mode ? (w_wdata ^ r_mode) : '0;
   assign w_mode_nxt = w_wr_mode ? w_wdata : r_mode;

   // Edge bits: set wins over W1C clear. Level bits: follow s.
   // Any bit whose mode flips this cycle is forced clear.
   assign w_pend_nxt = ~w_mode_chg &
                       ((r_mode & ((r_pend & ~w_clr) | w_edge)) | (~r_mode & w_s));

   assign bus.wt       = w_wt;
   assign bus.data_out = r_dout;
   assign irq          = r_irq;
   assign irq_any      = r_irq_any;

   // Highest-index active interrupt.
   always_comb begin
      w_id = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (r_irq[i]) w_id = 5'(i);
      end
   end

   // Read data mux; bits at or above NUM_SRC read as zero.
   always_comb begin
      w_rdata = '0;
      case (bus.addr)
         2'd0:    w_rdata = 32'(r_pend);
         2'd1:    w_rdata = 32'(r_mask);
         2'd2:    w_rdata = 32'(r_mode);
         default: w_rdata = {r_irq_any, 26'b0, w_id};
      endcase
   end

   // Source synchronizer chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
         r_sync[0] <= src_irq;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   // Bus handshake flop and read data register (valid during the completing cycle).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done <= 1'b0;
         r_dout <= '0;
      end else begin
         r_done <= w_wt;
         r_dout <= w_rd_start ? w_rdata : '0;
      end
   end

   // Pending, mask, mode and edge history. History tracks s every cycle, which
   // also covers the reload on a mode change so no spurious edge appears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist <= '0;
         r_pend <= '0;
         r_mask <= '0;
         r_mode <= '0;
      end else begin
         r_hist <= w_s;
         r_pend <= w_pend_nxt;
         r_mode <= w_mode_nxt;
         if (w_wr_mask) r_mask <= w_wdata;
      end
   end

   // Masked interrupt outputs, one cycle behind PENDING/MASK.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_irq     <= '0;
         r_irq_any <= 1'b0;
      end else begin
         r_irq     <= r_pend & r_mask;
         r_irq_any <= |(r_pend & r_mask);
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed bus accesses push expected read data into a
// per-instance queue; a monitor pops and compares when a read completes.
module tb_irq_ctrl;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] src0;
   logic [15:0] irq0;
   logic        any0;
   logic [4:0]  src1;
   logic [4:0]  irq1;
   logic        any1;

   int checks = 0;
   int errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   irq_ctrl_if bus0();
   irq_ctrl_if bus1();

   irq_ctrl #(.NUM_SRC(16), .SYNC_STAGES(2)) u0 (
      .clk(clk), .reset(reset), .bus(bus0),
      .src_irq(src0), .irq(irq0), .irq_any(any0)
   );

   irq_ctrl #(.NUM_SRC(5), .SYNC_STAGES(2)) u1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .src_irq(src1), .irq(irq1), .irq_any(any1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One two-cycle access; reads queue their expected data first.
   task automatic acc(input int which, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input string nm);
      exp_t e;
      e.name = nm;
      e.exp  = exp;
      if (!w) begin
         if (which == 0) q0.push_back(e);
         else            q1.push_back(e);
      end
      if (which == 0) begin
         bus0.en = 1'b1; bus0.wr = w; bus0.addr = a; bus0.data_in = d;
      end else begin
         bus1.en = 1'b1; bus1.wr = w; bus1.addr = a; bus1.data_in = d;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus0.en = 1'b0;
      bus1.en = 1'b0;
   endtask

   task automatic wr0(input logic [1:0] a, input logic [31:0] d);
      acc(0, 1'b1, a, d, 32'h0, "");
   endtask

   task automatic rd0(input logic [1:0] a, input logic [31:0] exp, input string nm);
      acc(0, 1'b0, a, 32'h0, exp, nm);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare data_out in every completing read cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus0.en && !bus0.wt && !bus0.wr) begin
            if (q0.size() == 0) chk("u0_unexpected_read", bus0.data_out, 32'hDEAD_BEEF);
            else begin
               e = q0.pop_front();
               chk(e.name, bus0.data_out, e.exp);
            end
         end
         if (bus1.en && !bus1.wt && !bus1.wr) begin
            if (q1.size() == 0) chk("u1_unexpected_read", bus1.data_out, 32'hDEAD_BEEF);
            else begin
               e = q1.pop_front();
               chk(e.name, bus1.data_out, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      src0 = '0; src1 = '0;
      bus0.en = 1'b0; bus0.wr = 1'b0; bus0.addr = 2'd0; bus0.data_in = '0;
      bus1.en = 1'b0; bus1.wr = 1'b0; bus1.addr = 2'd0; bus1.data_in = '0;

      // Reset state: wt follows en, outputs cleared.
      #3 bus0.en = 1'b1;
      #1 chk("rst_wt_eq_en", 32'(bus0.wt), 32'd1);
      bus0.en = 1'b0;
      #1 chk("rst_wt_idle", 32'(bus0.wt), 32'd0);
      chk("rst_irq", 32'(irq0), 32'h0);
      chk("rst_dout", bus0.data_out, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      idle(1);

      rd0(2'd0, 32'h0, "rst_pending");
      rd0(2'd1, 32'h0, "rst_mask");
      rd0(2'd2, 32'h0, "rst_mode");
      rd0(2'd3, 32'h0, "rst_id");
      chk("dout_zero_after_read", bus0.data_out, 32'h0);

      // Unimplemented bits read as zero.
      wr0(2'd1, 32'hFFFF_FFFF);
      rd0(2'd1, 32'h0000_FFFF, "mask16_wide_write");
      acc(1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, "");
      acc(1, 1'b0, 2'd1, 32'h0, 32'h0000_001F, "mask5_wide_write");

      // Level source 14: irq appears SYNC_STAGES+2 edges after the source rises.
      src0[14] = 1'b1;
      idle(3);
      chk("lvl_irq_early", 32'(irq0), 32'h0);
      idle(1);
      chk("lvl_irq", 32'(irq0), 32'h4000);
      chk("lvl_irq_any", 32'(any0), 32'd1);
      rd0(2'd3, 32'h8000_000E, "lvl_id");
      rd0(2'd0, 32'h0000_4000, "lvl_pending");
      wr0(2'd0, 32'h0000_4000);
      idle(1);
      rd0(2'd0, 32'h0000_4000, "lvl_w1c_ignored");
      src0[14] = 1'b0;
      idle(5);
      chk("lvl_irq_drop", 32'(irq0), 32'h0);
      chk("lvl_any_drop", 32'(any0), 32'd0);

      // ID writes ignored; bit 4 to edge mode.
      wr0(2'd3, 32'h0000_1234);
      wr0(2'd2, 32'h0000_0010);
      rd0(2'd2, 32'h0000_0010, "mode_rb");
      rd0(2'd3, 32'h0, "id_write_ignored");

      // One-cycle pulse latches in edge mode, W1C clears, irq follows a cycle later.
      src0[4] = 1'b1;
      idle(1);
      src0[4] = 1'b0;
      idle(6);
      chk("edge_irq", 32'(irq0), 32'h10);
      rd0(2'd0, 32'h0000_0010, "edge_pending");
      idle(5);
      rd0(2'd0, 32'h0000_0010, "edge_persist");
      wr0(2'd0, 32'h0000_0010);
      chk("edge_irq_lag", 32'(irq0), 32'h10);
      idle(1);
      chk("edge_irq_clr", 32'(irq0), 32'h0);
      rd0(2'd0, 32'h0, "edge_w1c");

      // Edge arrives in the same cycle as the W1C commit: set wins.
      src0[4] = 1'b1;
      idle(1);
      wr0(2'd0, 32'h0000_0010);
      idle(1);
      rd0(2'd0, 32'h0000_0010, "set_beats_clear");
      src0[4] = 1'b0;
      idle(4);
      wr0(2'd0, 32'h0000_0010);
      idle(1);
      rd0(2'd0, 32'h0, "edge_clear_again");

      // Mode change clears pending and does not fake an edge from a high source.
      src0[5] = 1'b1;
      idle(5);
      rd0(2'd0, 32'h0000_0020, "lvl5_pending");
      wr0(2'd2, 32'h0000_0030);
      idle(2);
      rd0(2'd0, 32'h0, "mode_chg_clears");
      src0[5] = 1'b0;
      wr0(2'd2, 32'h0000_0010);

      // Highest index wins in ID; masking removes irq.
      src0[1] = 1'b1; src0[3] = 1'b1;
      idle(5);
      rd0(2'd3, 32'h8000_0003, "id_1_3");
      wr0(2'd1, 32'h0);
      idle(1);
      rd0(2'd3, 32'h0, "id_masked");
      chk("masked_irq_any", 32'(any0), 32'd0);
      chk("masked_irq", 32'(irq0), 32'h0);
      rd0(2'd0, 32'h0000_000A, "pending_1_3");
      src0[1] = 1'b0; src0[3] = 1'b0;

      // en withdrawn before the completing cycle: no write.
      bus0.en = 1'b1; bus0.wr = 1'b1; bus0.addr = 2'd1; bus0.data_in = 32'h3;
      #1 chk("abort_wt", 32'(bus0.wt), 32'd1);
      @(posedge clk); #1;
      bus0.en = 1'b0;
      idle(2);
      rd0(2'd1, 32'h0, "abort_no_write");

      // Reset during the wait cycle of a write.
      wr0(2'd1, 32'h0000_FFFF);
      src0[2] = 1'b1;
      idle(5);
      chk("pre_rst_irq", 32'(irq0), 32'h4);
      bus0.en = 1'b1; bus0.wr = 1'b1; bus0.addr = 2'd2; bus0.data_in = 32'h0000_00FF;
      #1 chk("mid_wt", 32'(bus0.wt), 32'd1);
      #1 reset = 1'b0;
      #1 chk("mid_rst_irq", 32'(irq0), 32'h0);
      chk("mid_rst_any", 32'(any0), 32'd0);
      chk("mid_rst_wt", 32'(bus0.wt), 32'd1);
      bus0.en = 1'b0;
      src0[2] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(1);
      rd0(2'd0, 32'h0, "post_rst_pending");
      rd0(2'd1, 32'h0, "post_rst_mask");
      rd0(2'd2, 32'h0, "post_rst_mode");
      rd0(2'd3, 32'h0, "post_rst_id");
      acc(1, 1'b0, 2'd1, 32'h0, 32'h0, "u1_post_rst_mask");

      idle(3);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16, meaning number of interrupt sources (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth per source (legal 2..3).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: bus access request.
REQ-007 SHALL have port wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port addr[3:2], input, 2 bits: register select.
REQ-009 SHALL have port data_in, input, 32 bits: write data.
REQ-010 SHALL have port data_out, output, 32 bits: read data.
REQ-011 SHALL have port wt, output, 1 bit: wait, high while the access is not yet complete.
REQ-012 SHALL have port src_irq, input, NUM_SRC bits: asynchronous raw interrupt sources.
REQ-013 SHALL have port irq, output, NUM_SRC bits: masked pending vector, feeds cpu irq.
REQ-014 SHALL have port irq_any, output, 1 bit: OR of irq.

Function
REQ-015 SHALL synchronize each src_irq bit through SYNC_STAGES flops; s[i] denotes the synchronized value.
REQ-016 SHALL provide registers: addr 0 PENDING (R, W1C), addr 1 MASK (RW), addr 2 MODE (RW, 1 = edge, 0 = level), addr 3 ID (R).
REQ-017 SHALL complete each access in two cycles:
- first cycle of en: wt=1;
- second cycle: wt=0, data_out valid, write committed.
REQ-018 SHALL implement wt as en AND NOT done, where done is a flop loaded each cycle with en AND NOT done.
REQ-019 SHALL register data_out, and SHALL hold data_out at 0 when no read completes.
REQ-020 SHALL, in level mode, load PENDING[i] with s[i] every cycle; W1C writes to level bits SHALL have no effect.
REQ-021 SHALL, in edge mode, set PENDING[i] on a 0->1 transition of s[i], and SHALL clear it only by a W1C write of 1 to that bit.
REQ-022 SHALL give set priority over clear when an edge and a W1C clear of the same bit occur in the same cycle.
REQ-023 SHALL, for each bit whose mode changes on a MODE write:
- clear PENDING[i];
- reload the edge-detector history with current s[i], so no spurious edge occurs.
REQ-024 SHALL register irq as PENDING AND MASK, giving one cycle latency from a PENDING change to irq.
REQ-025 SHALL register irq_any together with irq.
REQ-026 SHALL return from ID:
- bit 31 = irq_any;
- bits 4:0 = highest index i with irq[i]=1, or 0 if none;
- other bits 0.
REQ-027 SHALL ignore writes to ID.
REQ-028 SHALL read bits at or above NUM_SRC as 0 and SHALL ignore writes to them.
REQ-029 SHALL treat a new en in the cycle after completion as a fresh two-cycle access (back-to-back accesses allowed).
REQ-030 SHALL, if en drops while wt=1, abort the access with no register change.

Reset
REQ-031 SHALL, while reset=0, asynchronously clear: PENDING, MASK, MODE (all level), synchronizers, edge history, done, irq, irq_any, data_out.
REQ-032 SHALL make wt equal en during reset, since done=0.
REQ-033 SHALL not detect an edge in the first cycle after reset release from a source already high.

Verification
REQ-034 SHALL be verified with: write MASK=0x0000FFFF; hold src_irq[14]=1 in level mode -> irq=0x4000 after SYNC_STAGES+2 cycles, ID reads 0x8000000E.
REQ-035 SHALL be verified with: MODE=0x00000010; pulse src_irq[4] for 1 cycle -> PENDING=0x10 persists; W1C 0x10 -> PENDING=0, irq[4]=0 one cycle later.
REQ-036 SHALL be verified with: an edge on bit 4 in the same cycle as a W1C 0x10 -> PENDING[4]=1 afterwards.
REQ-037 SHALL be verified with: sources 1 and 3 pending and enabled -> ID reads 0x80000003; MASK=0 -> ID reads 0x00000000, irq_any=0.
REQ-038 SHALL be verified with: NUM_SRC=5; write MASK=0xFFFFFFFF -> read 0x0000001F.
REQ-039 SHALL be verified with: assert reset mid-access (wt=1) -> all registers 0, no write committed, irq=0.
